// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit
//   Hazard detection and operand forwarding for the five-stage MIPS pipeline
//   (IF/ID/EX/MEM/WB). The unit keeps its own copy of the destination and
//   control bits for the EX, MEM and WB stages. From that registered state
//   and the current ID/branch inputs it drives the PC and IF/ID enables, the
//   flushes and the forwarding selects, all combinationally.
//
//   Optional feature macro: MIPS_HAZARD_PERF_EN
//     defined   -> stall_count / flush_count are saturating counters
//     undefined -> no counter flops; both counters are tied to 0
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   id_*                ID-stage instruction fields and control bits
//   ex_branch_taken     branch/jump resolved taken in EX
//   pc_write_en         PC may update
//   ifid_write_en       IF/ID may load
//   ifid_flush          IF/ID loads a bubble
//   idex_flush          ID/EX loads a bubble
//   fwd_a, fwd_b        EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   id_fwd_a, id_fwd_b  ID read takes WB write data (same-cycle write/read)
//   stall_count         stall cycles seen (saturating)
//   flush_count         flush cycles seen (saturating)
module mips_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_branch_taken,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_fwd_a,
  output logic                  id_fwd_b,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } stageRec_t;

  // EX also carries its source operands so forwarding can be resolved there.
  typedef struct packed {
    stageRec_t             base;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  usesRs;
    logic                  usesRt;
  } exRec_t;

  exRec_t    exQ;
  stageRec_t memQ, wbQ;

  // Register 0 is hardwired to zero, so a write to it never counts as a
  // hazard or forward source.
  function automatic logic effWrite(input stageRec_t s);
    return s.valid & s.regwrite & (s.dest != '0);
  endfunction

  logic loadUse, brFlush;
  logic memWr, wbWr;

  assign memWr = effWrite(memQ);
  assign wbWr  = effWrite(wbQ);

  assign loadUse = exQ.base.valid & exQ.base.memread & (exQ.base.dest != '0) & id_valid &
                   ((id_uses_rs & (id_rs == exQ.base.dest)) |
                    (id_uses_rt & (id_rt == exQ.base.dest)));
  assign brFlush = ex_branch_taken & exQ.base.valid;

  // A flush wins over a stall. The wrong-path instruction in ID is
  // discarded, so holding it back would serve no purpose.
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    if (brFlush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (loadUse) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_flush    = 1'b1;
    end
  end

  // The MEM stage holds the newer value, so it takes priority over WB.
  // A load in MEM has no data yet; that case was already covered by the
  // load-use stall one cycle earlier.
  function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] src, input logic uses);
    logic [1:0] sel;
    sel = 2'b00;
    if (exQ.base.valid & uses) begin
      if (memWr & ~memQ.memread & (memQ.dest == src))
        sel = 2'b10;
      else if (wbWr & (wbQ.dest == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_a = fwdSel(exQ.rs, exQ.usesRs);
  assign fwd_b = fwdSel(exQ.rt, exQ.usesRt);

  // The regfile writes and reads in the same cycle, so ID bypasses WB data.
  assign id_fwd_a = wbWr & id_valid & id_uses_rs & (wbQ.dest == id_rs);
  assign id_fwd_b = wbWr & id_valid & id_uses_rt & (wbQ.dest == id_rt);

  always_ff @(posedge clk) begin
    if (reset) begin
      exQ  <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      wbQ               <= memQ;
      memQ              <= exQ.base;
      exQ.base.valid    <= id_valid & ~idex_flush;
      exQ.base.dest     <= id_dest;
      exQ.base.regwrite <= id_regwrite;
      exQ.base.memread  <= id_memread;
      exQ.rs            <= id_rs;
      exQ.rt            <= id_rt;
      exQ.usesRs        <= id_uses_rs;
      exQ.usesRt        <= id_uses_rt;
    end
  end

`ifdef MIPS_HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] stallCnt, flushCnt;
  // A stall hidden by a simultaneous flush never takes effect, so it is not
  // counted.
  logic stallEvt;
  assign stallEvt = loadUse & ~brFlush;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallEvt && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
      if (brFlush  && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign stall_count = stallCnt;
  assign flush_count = flushCnt;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Testbench for mips_hazard_unit: directed scenarios plus randomized traffic.
// Every cycle is checked against an instruction-level pipeline model.
module tb_mips_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 2;

  logic clk = 0, reset;
  logic id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, ex_branch_taken;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic pc_write_en, ifid_write_en, ifid_flush, idex_flush, id_fwd_a, id_fwd_b;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  mips_hazard_unit #(.REG_ADDR_W(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .id_fwd_a(id_fwd_a),
    .id_fwd_b(id_fwd_b), .stall_count(stall_count), .flush_count(flush_count));

  int nChecks = 0, nErrs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per instruction in flight; [0]=EX [1]=MEM [2]=WB.
  typedef struct {
    bit v, rw, mr, urs, urt;
    int dest, rs, rt;
  } instr_t;
  instr_t pipe[3];
  int mStall, mFlush;
  localparam int CMAX = (1 << CW) - 1;

  function automatic bit writes(instr_t i);
    return i.v && i.rw && i.dest != 0;
  endfunction

  function automatic int fwdRef(int src, bit uses);
    if (!pipe[0].v || !uses) return 0;
    if (writes(pipe[1]) && !pipe[1].mr && pipe[1].dest == src) return 2;
    if (writes(pipe[2]) && pipe[2].dest == src) return 1;
    return 0;
  endfunction

  // One cycle: inputs driven now, outputs checked on the falling edge,
  // model advanced on the rising edge.
  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int dest, input bit rw, input bit mr, input bit br, input bit rst);
    bit lu, fl, st;
    instr_t n;
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = AW'(dest); id_regwrite = rw; id_memread = mr; ex_branch_taken = br; reset = rst;
    @(negedge clk);
    lu = pipe[0].v && pipe[0].mr && pipe[0].dest != 0 && v &&
         ((urs && rs == pipe[0].dest) || (urt && rt == pipe[0].dest));
    fl = br && pipe[0].v;
    st = lu && !fl;
    check("pc_write_en",   32'(pc_write_en),   32'(!st));
    check("ifid_write_en", 32'(ifid_write_en), 32'(!st));
    check("ifid_flush",    32'(ifid_flush),    32'(fl));
    check("idex_flush",    32'(idex_flush),    32'(fl || st));
    check("fwd_a",         32'(fwd_a),         32'(fwdRef(rs, pipe[0].urs ? 1'b1 : 1'b0) & 0) | 32'(fwdRef(pipe[0].rs, pipe[0].urs)));
    check("fwd_b",         32'(fwd_b),         32'(fwdRef(pipe[0].rt, pipe[0].urt)));
    check("id_fwd_a",      32'(id_fwd_a),      32'(writes(pipe[2]) && v && urs && pipe[2].dest == rs));
    check("id_fwd_b",      32'(id_fwd_b),      32'(writes(pipe[2]) && v && urt && pipe[2].dest == rt));
`ifdef MIPS_HAZARD_PERF_EN
    check("stall_count",   32'(stall_count),   32'(mStall));
    check("flush_count",   32'(flush_count),   32'(mFlush));
`else
    check("stall_count",   32'(stall_count),   32'd0);
    check("flush_count",   32'(flush_count),   32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      foreach (pipe[i]) pipe[i] = '{default: 0};
      mStall = 0; mFlush = 0;
    end else begin
      n = '{v: v && !(fl || st), rw: rw, mr: mr, urs: urs, urt: urt, dest: dest, rs: rs, rt: rt};
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = n;
      if (fl && mFlush < CMAX) mFlush++;
      if (st && mStall < CMAX) mStall++;
    end
    #1;
  endtask

  // Shorthands: ALU op rd <- rs,rt ; load rd <- [rs] ; nop
  task automatic alu(int d, int s, int t); step(1, s, t, 1, 1, d, 1, 0, 0, 0); endtask
  task automatic lw(int d, int s);         step(1, s, 0, 1, 0, d, 1, 1, 0, 0); endtask
  task automatic nop();                    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    foreach (pipe[i]) pipe[i] = '{default: 0};
    mStall = 0; mFlush = 0;
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_pc", 32'(pc_write_en), 32'd1);
    check("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);

    // ALU chain: add $8 then add $9,$8,$8 -> consumer in EX forwards from MEM
    alu(8, 1, 2); alu(9, 8, 8); nop();
    // Distance 2 and distance 3
    alu(8, 1, 2); nop(); alu(10, 8, 11); nop(); nop();
    alu(8, 1, 2); nop(); nop(); alu(12, 8, 0); nop(); nop();
    // Load-use: one stall, then the consumer re-enters EX with fwd_a=01
    lw(8, 29);
    id_valid = 1; alu(9, 8, 10);
    check("lu_after_pc", 32'(pc_write_en), 32'd1);
    alu(9, 8, 10); nop(); nop();
    // Taken branch in EX while ID holds a load-use consumer
    lw(8, 29);
    step(1, 8, 10, 1, 1, 9, 1, 0, 1, 0);
    nop(); nop(); nop();
    // Writes to $zero never stall or forward
    lw(0, 29); alu(9, 0, 0); alu(0, 1, 2); alu(9, 0, 0); nop(); nop();
    // Back-to-back dependent loads: one stall per pair
    lw(8, 29); lw(9, 8); lw(9, 8); lw(10, 9); lw(10, 9); nop(); nop();
    // Five stalls to saturate the counters, then reset during a stall
    for (int i = 0; i < 5; i++) begin lw(8, 29); alu(9, 8, 8); alu(9, 8, 8); end
    lw(8, 29);
    step(1, 8, 8, 1, 1, 9, 1, 0, 0, 1);
    check("rst_stall_pc", 32'(pc_write_en), 32'd1);
    check("rst_stall_cnt", 32'(stall_count), 32'd0);

    // Random traffic over a small register set to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      bit rst = ($urandom_range(99) < 2);
      bit br  = ($urandom_range(99) < 12);
      step($urandom_range(9) != 0, $urandom_range(3), $urandom_range(3),
           $urandom_range(1), $urandom_range(1), $urandom_range(3),
           $urandom_range(1), $urandom_range(2) == 0, br, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
